auth_key_engine: RTL and testbench
==================================

// Module: auth_key_engine
// PURPOSE
//  Multi-channel successor of the single-slot authentication ALU. It holds per-channel key pairs (An, Mn) in an external
//  sync RAM. On request it computes N=alpha^An, An+1=N^Mn and beta=An+1+An, then returns beta. After a confirmation it
//  commits Mn+1=An+Mn and An+1, or it discards them on fail/timeout. It sits between the challenge front-end and the key RAM.
// PARAMETERS
//  W     256   datapath / key width (bits)
//  NCH   4     number of key channels (>=2)
//  CHW   $clog2(NCH)  channel index width (derived)
//  TMO   1024  max cycles waiting for confirmation (>=2)
// PORTS
//  CLK         in   1        clock
//  RST         in   1        reset, synchronous, active-high
//  req_valid   in   1        challenge request
//  req_ready   out  1        =1 only in IDLE with no ld_valid
//  req_ch      in   CHW      channel of request
//  req_alpha   in   W        challenge alpha
//  ld_valid    in   1        key provisioning request (IDLE only)
//  ld_ch       in   CHW      channel to provision
//  ld_a, ld_m  in   W        initial An, Mn
//  beta_valid  out  1        level, high throughout WAIT_CFM
//  beta        out  W        response, held until next accept
//  cfm_valid   in   1        confirmation strobe
//  cfm_ok      in   1        1=success (commit), 0=fail (discard)
//  mem_addr    out  CHW+1    {ch, sel}; sel 0=An, 1=Mn
//  mem_we      out  1        write strobe
//  mem_wdata   out  W        write data
//  mem_rdata   in   W        read data, valid 1 clk after address
//  busy        out  1        state != IDLE
//  done        out  1        1-clk pulse on commit or load complete
//  err_timeout out  1        1-clk pulse on confirmation timeout
// BEHAVIOUR
//  Reset: state=IDLE. beta, N, An, Mn, An+1 regs=0. Timeout counter=0. All outputs 0 except req_ready=1.
//  FSM: IDLE, RD_A, RD_M, CAP_M, BETA, WAIT_CFM, WR_M, WR_A, LD_A, LD_M.
//  IDLE: ld_valid has priority over req_valid; when ld_valid=1, req_ready=0 and req is not accepted.
//   ld_valid -> LD_A: latch ld_*. req_valid&req_ready -> RD_A: latch ch and alpha.
//  LD_A: write {ch,0}<=ld_a. LD_M: write {ch,1}<=ld_m, done=1 -> IDLE.
//  RD_A: addr {ch,0}. RD_M: addr {ch,1}; capture An=rdata, N=alpha^An.
//  CAP_M: capture Mn=rdata, An+1=N^Mn. BETA: beta<=An+1+An mod 2^W (carry dropped) -> WAIT_CFM.
//  beta_valid rises exactly 4 clk edges after the accepting edge.
//  WAIT_CFM: counter increments every cycle.
//   cfm_valid&cfm_ok -> WR_M. cfm_valid&!cfm_ok -> IDLE, no writes.
//   Counter reaching TMO-1 with no cfm -> IDLE, err_timeout=1, no writes.
//   cfm_valid in the same cycle as the counter reaching TMO-1 -> the cfm wins.
//  WR_M: mem_we=1, addr {ch,1}, wdata=An+Mn mod 2^W.
//  WR_A: mem_we=1, addr {ch,0}, wdata=An+1, done=1 -> IDLE.
//  cfm_valid outside WAIT_CFM and req_valid/ld_valid outside IDLE are ignored (not queued).
//  mem_we=0 in all states other than WR_*/LD_*. mem_addr/mem_wdata=0 in IDLE.
//  RST mid-operation: return to IDLE next edge, no further writes.
//   RST during WR_A leaves the channel with Mn already updated (documented hazard).
//  Channels are independent; only the addressed channel's two words are ever written.
// TESTING (bench W=8, NCH=4, TMO=16)
//  1 load ch2 A=3C M=5A; req ch2 alpha=A5 -> beta=FF at +4 clk; cfm ok -> RAM A2=C3, M2=96, done pulse.
//  2 load ch1 A=20 M=00; req alpha=D0 -> An+1=F0, beta=10 (carry wrap); cfm ok -> M1=20, A1=F0.
//  3 repeat test 1 setup; cfm_valid=1 cfm_ok=0 -> IDLE, no mem_we, RAM A2=3C M2=5A unchanged.
//  4 no cfm for 16 clk in WAIT_CFM -> err_timeout 1-clk pulse, IDLE, no writes; next req accepted.
//  5 ld_valid and req_valid same cycle in IDLE -> load runs first, req_ready=0; req accepted after done.
//  6 RST asserted in WAIT_CFM and again in WR_M -> IDLE next edge, outputs reset; no further mem_we.

Source files
------------

// File: rtl/auth_key_engine_if.sv
// Bundle between the challenge front-end / key RAM and auth_key_engine.
// The slave modport is the engine's view; master is the surrounding system.
interface auth_key_engine_if #(
    parameter int unsigned W   = 256,
    parameter int unsigned NCH = 4
);
    localparam int unsigned CHW = $clog2(NCH);

    logic           req_valid;
    logic           req_ready;
    logic [CHW-1:0] req_ch;
    logic [W-1:0]   req_alpha;
    logic           ld_valid;
    logic [CHW-1:0] ld_ch;
    logic [W-1:0]   ld_a;
    logic [W-1:0]   ld_m;
    logic           beta_valid;
    logic [W-1:0]   beta;
    logic           cfm_valid;
    logic           cfm_ok;
    logic [CHW:0]   mem_addr;
    logic           mem_we;
    logic [W-1:0]   mem_wdata;
    logic [W-1:0]   mem_rdata;
    logic           busy;
    logic           done;
    logic           err_timeout;

    modport slave (
        input  req_valid, req_ch, req_alpha, ld_valid, ld_ch, ld_a, ld_m,
               cfm_valid, cfm_ok, mem_rdata,
        output req_ready, beta_valid, beta, mem_addr, mem_we, mem_wdata,
               busy, done, err_timeout
    );

    modport master (
        output req_valid, req_ch, req_alpha, ld_valid, ld_ch, ld_a, ld_m,
               cfm_valid, cfm_ok, mem_rdata,
        input  req_ready, beta_valid, beta, mem_addr, mem_we, mem_wdata,
               busy, done, err_timeout
    );
endinterface

// File: rtl/auth_key_engine.sv
// Multi-channel authentication key engine: reads (An, Mn) from key RAM, returns
// beta = (alpha^An^Mn) + An, and commits or discards the key update on confirmation.
module auth_key_engine #(
    parameter int unsigned W   = 256,
    parameter int unsigned NCH = 4,
    parameter int unsigned TMO = 1024
) (
    input  logic               CLK,
    input  logic               RST,
    auth_key_engine_if.slave   io_bus
);
    localparam int unsigned CHW  = $clog2(NCH);
    localparam int unsigned CNTW = $clog2(TMO);

    typedef enum logic [3:0] {
        IDLE, RD_A, RD_M, CAP_M, BETA, WAIT_CFM, WR_M, WR_A, LD_A, LD_M
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CHW-1:0]  r_ch;
    logic [W-1:0]    r_alpha;
    logic [W-1:0]    r_an;
    logic [W-1:0]    r_mn;
    logic [W-1:0]    r_n;
    logic [W-1:0]    r_anx;
    logic [W-1:0]    r_beta;
    logic [CNTW-1:0] r_cnt;
    logic            w_we;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_alpha <= '0;
            r_an    <= '0;
            r_mn    <= '0;
            r_n     <= '0;
            r_anx   <= '0;
            r_beta  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == WAIT_CFM && w_next == WAIT_CFM) ? r_cnt + 1'b1 : '0;
            case (r_state)
                IDLE: begin
                    // Load values reuse the An/Mn holding registers
                    if (io_bus.ld_valid) begin
                        r_ch <= io_bus.ld_ch;
                        r_an <= io_bus.ld_a;
                        r_mn <= io_bus.ld_m;
                    end else if (io_bus.req_valid) begin
                        r_ch    <= io_bus.req_ch;
                        r_alpha <= io_bus.req_alpha;
                    end
                end
                RD_M: begin
                    r_an <= io_bus.mem_rdata;
                    r_n  <= r_alpha ^ io_bus.mem_rdata;
                end
                CAP_M: begin
                    r_mn  <= io_bus.mem_rdata;
                    r_anx <= r_n ^ io_bus.mem_rdata;
                end
                BETA:    r_beta <= r_anx + r_an;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next             = r_state;
        w_we               = 1'b0;
        io_bus.req_ready   = 1'b0;
        io_bus.beta_valid  = 1'b0;
        io_bus.mem_addr    = '0;
        io_bus.mem_wdata   = '0;
        io_bus.done        = 1'b0;
        io_bus.err_timeout = 1'b0;
        io_bus.busy        = (r_state != IDLE);
        io_bus.beta        = r_beta;

        case (r_state)
            IDLE: begin
                io_bus.req_ready = !io_bus.ld_valid;
                if (io_bus.ld_valid)       w_next = LD_A;
                else if (io_bus.req_valid) w_next = RD_A;
            end
            LD_A: begin
                w_we             = 1'b1;
                io_bus.mem_addr  = {r_ch, 1'b0};
                io_bus.mem_wdata = r_an;
                w_next           = LD_M;
            end
            LD_M: begin
                w_we             = 1'b1;
                io_bus.mem_addr  = {r_ch, 1'b1};
                io_bus.mem_wdata = r_mn;
                io_bus.done      = 1'b1;
                w_next           = IDLE;
            end
            RD_A: begin
                io_bus.mem_addr = {r_ch, 1'b0};
                w_next          = RD_M;
            end
            RD_M: begin
                io_bus.mem_addr = {r_ch, 1'b1};
                w_next          = CAP_M;
            end
            CAP_M: w_next = BETA;
            BETA:  w_next = WAIT_CFM;
            WAIT_CFM: begin
                io_bus.beta_valid = 1'b1;
                // A confirmation arriving on the last counted cycle beats the timeout
                if (io_bus.cfm_valid) begin
                    w_next = io_bus.cfm_ok ? WR_M : IDLE;
                end else if (r_cnt == CNTW'(TMO - 1)) begin
                    io_bus.err_timeout = 1'b1;
                    w_next             = IDLE;
                end
            end
            WR_M: begin
                w_we             = 1'b1;
                io_bus.mem_addr  = {r_ch, 1'b1};
                io_bus.mem_wdata = r_an + r_mn;
                w_next           = WR_A;
            end
            WR_A: begin
                w_we             = 1'b1;
                io_bus.mem_addr  = {r_ch, 1'b0};
                io_bus.mem_wdata = r_anx;
                io_bus.done      = 1'b1;
                w_next           = IDLE;
            end
            default: w_next = IDLE;
        endcase

        // A write must never land in the same cycle reset is asserted
        io_bus.mem_we = w_we && !RST;
    end
endmodule

// File: tb/tb_auth_key_engine.sv
// Directed bench for auth_key_engine (W=8, NCH=4, TMO=16) with a sync-read key RAM.
module tb_auth_key_engine;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   we_cnt   = 0;
    int   done_cnt = 0;
    int   to_cnt   = 0;
    int   we_snap, done_snap, to_snap;
    logic [7:0] ram [0:7];

    always #5 CLK = ~CLK;

    auth_key_engine_if #(.W(8), .NCH(4)) bus ();

    auth_key_engine #(.W(8), .NCH(4), .TMO(16)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .io_bus (bus)
    );

    initial for (int i = 0; i < 8; i++) ram[i] = 8'h00;

    always @(posedge CLK) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
        if (bus.mem_we)      we_cnt   <= we_cnt + 1;
        if (bus.done)        done_cnt <= done_cnt + 1;
        if (bus.err_timeout) to_cnt   <= to_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] ch, input logic [7:0] a, input logic [7:0] m);
        bus.ld_valid = 1'b1; bus.ld_ch = ch; bus.ld_a = a; bus.ld_m = m;
        tick();
        bus.ld_valid = 1'b0;
        tick();
        chk("ld_done", bus.done, 1);
        tick();
        chk("ld_ramA", ram[{ch, 1'b0}], a);
        chk("ld_ramM", ram[{ch, 1'b1}], m);
    endtask

    task automatic req_beta(input logic [1:0] ch, input logic [7:0] alpha, input logic [7:0] exp_beta);
        for (int i = 0; i < 40 && !bus.req_ready; i++) tick();
        chk("req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_ch = ch; bus.req_alpha = alpha;
        tick();
        bus.req_valid = 1'b0;
        tick(); tick(); tick();
        chk("beta_valid_early", bus.beta_valid, 0);
        tick();
        chk("beta_valid", bus.beta_valid, 1);
        chk("beta", bus.beta, exp_beta);
    endtask

    task automatic cfm_commit(input logic [1:0] ch, input logic [7:0] exp_a, input logic [7:0] exp_m);
        done_snap = done_cnt;
        bus.cfm_valid = 1'b1; bus.cfm_ok = 1'b1;
        tick();
        bus.cfm_valid = 1'b0;
        chk("wrm_we", bus.mem_we, 1);
        chk("wrm_addr", bus.mem_addr, {ch, 1'b1});
        chk("wrm_data", bus.mem_wdata, exp_m);
        tick();
        chk("wra_we", bus.mem_we, 1);
        chk("wra_addr", bus.mem_addr, {ch, 1'b0});
        chk("wra_data", bus.mem_wdata, exp_a);
        chk("wra_done", bus.done, 1);
        tick();
        chk("commit_idle", bus.busy, 0);
        chk("commit_ramA", ram[{ch, 1'b0}], exp_a);
        chk("commit_ramM", ram[{ch, 1'b1}], exp_m);
        chk("commit_done_once", done_cnt - done_snap, 1);
    endtask

    task automatic cfm_fail();
        bus.cfm_valid = 1'b1; bus.cfm_ok = 1'b0;
        tick();
        bus.cfm_valid = 1'b0;
        chk("fail_idle", bus.busy, 0);
    endtask

    initial begin
        bus.req_valid = 0; bus.req_ch = 0; bus.req_alpha = 0;
        bus.ld_valid = 0; bus.ld_ch = 0; bus.ld_a = 0; bus.ld_m = 0;
        bus.cfm_valid = 0; bus.cfm_ok = 0;
        tick(); tick();
        RST = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_beta", bus.beta, 0);
        chk("rst_beta_valid", bus.beta_valid, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err_timeout, 0);

        // 1: basic commit on ch2
        load(2'd2, 8'h3C, 8'h5A);
        req_beta(2'd2, 8'hA5, 8'hFF);
        cfm_commit(2'd2, 8'hC3, 8'h96);

        // 2: carry wrap on ch1
        load(2'd1, 8'h20, 8'h00);
        req_beta(2'd1, 8'hD0, 8'h10);
        cfm_commit(2'd1, 8'hF0, 8'h20);
        chk("ch2_untouched", ram[4], 8'hC3);

        // 3: failed confirmation discards
        load(2'd2, 8'h3C, 8'h5A);
        req_beta(2'd2, 8'hA5, 8'hFF);
        we_snap = we_cnt;
        cfm_fail();
        chk("fail_no_we", we_cnt - we_snap, 0);
        chk("fail_ramA", ram[4], 8'h3C);
        chk("fail_ramM", ram[5], 8'h5A);

        // 4: timeout, then cfm on the last counted cycle wins
        req_beta(2'd2, 8'h00, 8'hA2);
        we_snap = we_cnt; to_snap = to_cnt;
        for (int i = 0; i < 14; i++) tick();
        chk("to_not_yet", bus.err_timeout, 0);
        chk("to_still_wait", bus.beta_valid, 1);
        tick();
        chk("to_pulse", bus.err_timeout, 1);
        tick();
        chk("to_pulse_end", bus.err_timeout, 0);
        chk("to_idle", bus.busy, 0);
        chk("to_count", to_cnt - to_snap, 1);
        chk("to_no_we", we_cnt - we_snap, 0);
        req_beta(2'd2, 8'hA5, 8'hFF);
        to_snap = to_cnt;
        for (int i = 0; i < 15; i++) tick();
        bus.cfm_valid = 1'b1; bus.cfm_ok = 1'b1;
        #1;
        chk("cfm_wins_no_err", bus.err_timeout, 0);
        cfm_commit(2'd2, 8'hC3, 8'h96);
        chk("cfm_wins_to_count", to_cnt - to_snap, 0);

        // 5: load has priority over a simultaneous request
        bus.ld_valid = 1'b1; bus.ld_ch = 2'd3; bus.ld_a = 8'h11; bus.ld_m = 8'h22;
        bus.req_valid = 1'b1; bus.req_ch = 2'd3; bus.req_alpha = 8'hFF;
        #1;
        chk("prio_ready_low", bus.req_ready, 0);
        tick();
        bus.ld_valid = 1'b0;
        chk("prio_ld_busy", bus.busy, 1);
        chk("prio_ready_busy", bus.req_ready, 0);
        tick();
        chk("prio_ld_done", bus.done, 1);
        tick();
        chk("prio_ready_after", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        tick(); tick(); tick();
        chk("prio_bv_early", bus.beta_valid, 0);
        tick();
        chk("prio_beta", bus.beta, 8'hDD);
        chk("prio_ramA", ram[6], 8'h11);
        chk("prio_ramM", ram[7], 8'h22);
        cfm_fail();

        // 6: reset in WAIT_CFM and in WR_M
        req_beta(2'd1, 8'h00, 8'hC0);
        tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("rst_wait_busy", bus.busy, 0);
        chk("rst_wait_beta", bus.beta, 0);
        chk("rst_wait_bv", bus.beta_valid, 0);
        chk("rst_wait_ready", bus.req_ready, 1);
        req_beta(2'd1, 8'h00, 8'hC0);
        we_snap = we_cnt;
        bus.cfm_valid = 1'b1; bus.cfm_ok = 1'b1;
        tick();
        bus.cfm_valid = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_wrm_we_gated", bus.mem_we, 0);
        tick();
        RST = 1'b0;
        #1;
        chk("rst_wrm_busy", bus.busy, 0);
        tick();
        chk("rst_wrm_no_we", we_cnt - we_snap, 0);
        chk("rst_wrm_ramA", ram[2], 8'hF0);
        chk("rst_wrm_ramM", ram[3], 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
